// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Line levels and the FSM state encoding live here.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int   CLKS_PER_BIT_DEF = 87;
  localparam logic LINE_IDLE        = 1'b1;
  localparam logic START_BIT        = 1'b0;
  localparam logic STOP_BIT         = 1'b1;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with registered occupancy count.
// Pushes into a full FIFO and pops from an empty one are ignored.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [7:0]                   din,
  input  logic                         pop,
  output logic [7:0]                   dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d   = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= din;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for 8E1 framing.
// Line outputs are registered from the current state, one cycle behind it.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              i_Clock,
  input  logic                              i_Reset_n,
  input  logic                              i_Tx_DV,
  input  logic [7:0]                        i_Tx_Byte,
  output logic                              o_Tx_Ready,
  output logic                              o_Tx_Serial,
  output logic                              o_Tx_Active,
  output logic                              o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_Fifo_Count
);

  localparam int            BW       = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          serial_q, serial_d;
  logic          active_q, active_d;
  logic          done_q, done_d;
  logic          push;
  logic          pop;
  logic          baud_last;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;

  assign o_Tx_Ready  = !fifo_full;
  assign push        = i_Tx_DV && o_Tx_Ready;
  assign baud_last   = (baud_q == BAUD_MAX);
  assign o_Tx_Serial = serial_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_Clock),
    .rst_n (i_Reset_n),
    .push  (push),
    .din   (i_Tx_Byte),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (o_Fifo_Count)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      serial_q <= LINE_IDLE;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          state_d = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit when more data waits.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    serial_d = LINE_IDLE;
    active_d = (state_q != IDLE);
    done_d   = (state_q == STOP) && baud_last;
    unique case (state_q)
      START:   serial_d = START_BIT;
      DATA:    serial_d = shift_q[bit_q];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_d = ^shift_q;
`endif
      STOP:    serial_d = STOP_BIT;
      default: serial_d = LINE_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Observed vector per cycle: {serial, active, done, ready, count[2:0]}.
module tb_uart_tx_buffered;

  localparam int C    = 4;
  localparam int D    = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB   = 11;
`else
  localparam int FB   = 10;
`endif
  localparam int FL   = FB * C;
  localparam int MAXC = 512;
  localparam logic [6:0] QUIET = 7'b1001000;

  logic       clk;
  logic       rst_n;
  logic       dv;
  logic [7:0] txb;
  logic       rdy;
  logic       ser;
  logic       act;
  logic       done;
  logic [2:0] cnt;

  int n_cmp;
  int n_bad;

  logic [6:0] cap  [MAXC];
  logic [6:0] expv [MAXC];
  bit         e_ln  [MAXC];
  bit         e_act [MAXC];
  bit         e_done[MAXC];
  int         e_cnt [MAXC];

  uart_tx_buffered #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .i_Clock      (clk),
    .i_Reset_n    (rst_n),
    .i_Tx_DV      (dv),
    .i_Tx_Byte    (txb),
    .o_Tx_Ready   (rdy),
    .o_Tx_Serial  (ser),
    .o_Tx_Active  (act),
    .o_Tx_Done    (done),
    .o_Fifo_Count (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] obs();
    return {ser, act, done, rdy, cnt};
  endfunction

  function automatic bit frame_bit(input int v, input int b);
    logic [7:0] d;
    d = v[7:0];
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (FB == 11 && b == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int wr[$], input int i);
    if (i < wr.size() && wr[i] >= 0) begin
      dv  = 1'b1;
      txb = wr[i][7:0];
    end else begin
      dv  = 1'b0;
    end
  endtask

  task automatic apply_reset();
    dv    = 1'b0;
    txb   = 8'h00;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Entry i of wr is offered at edge i (-1 = no write); cap[k] sampled after edge k.
  task automatic run_frames(input int wr[$], input int ncyc);
    drive(wr, 0);
    tick();
    for (int k = 0; k < ncyc; k++) begin
      cap[k] = obs();
      drive(wr, k + 1);
      tick();
    end
    dv = 1'b0;
  endtask

  // Reference: a byte queue and a transmitter that is free again FL edges after a pop.
  task automatic model(input int wr[$], input int ncyc);
    int q[$];
    int free_at;
    int occ0;
    int pb;
    int idx;
    free_at = 0;
    for (int k = 0; k < MAXC; k++) begin
      e_ln[k]   = 1'b1;
      e_act[k]  = 1'b0;
      e_done[k] = 1'b0;
      e_cnt[k]  = 0;
    end
    for (int e = 0; e < ncyc; e++) begin
      occ0 = q.size();
      if (e >= free_at) begin
        if (occ0 > 0) begin
          pb = q.pop_front();
          for (int b = 0; b < FB; b++) begin
            for (int c = 0; c < C; c++) begin
              idx = e + 1 + b * C + c;
              if (idx < MAXC) begin
                e_ln[idx]  = frame_bit(pb, b);
                e_act[idx] = 1'b1;
              end
            end
          end
          if (e + FL < MAXC) e_done[e + FL] = 1'b1;
          free_at = e + FL;
        end else begin
          free_at = e + 1;
        end
      end
      if (e < wr.size() && wr[e] >= 0 && occ0 < D) q.push_back(wr[e]);
      e_cnt[e] = q.size();
    end
    for (int k = 0; k < ncyc; k++) begin
      expv[k] = {e_ln[k], e_act[k], e_done[k], (e_cnt[k] < D), 3'(e_cnt[k])};
    end
  endtask

  task automatic test_reset();
    dv    = 1'b0;
    txb   = 8'h00;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== QUIET) begin
      n_bad++;
      $display("FAIL reset_hold got %b want %b", obs(), QUIET);
    end
    tick();
    tick();
    n_cmp++;
    if (obs() !== QUIET) begin
      n_bad++;
      $display("FAIL reset_hold2 got %b want %b", obs(), QUIET);
    end
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (obs() !== QUIET) begin
      n_bad++;
      $display("FAIL reset_release got %b want %b", obs(), QUIET);
    end
  endtask

  task automatic test_single();
    int wr[$];
    int seq[11];
    int dn;
    int ncyc;
`ifdef UART_TX_PARITY_EN
    seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
    seq = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
`endif
    apply_reset();
    wr   = '{32'hA5};
    ncyc = FL + 10;
    model(wr, ncyc);
    run_frames(wr, ncyc);
    for (int k = 0; k < ncyc; k++) begin
      n_cmp++;
      if (cap[k] !== expv[k]) begin
        n_bad++;
        $display("FAIL single cyc %0d got %b want %b", k, cap[k], expv[k]);
      end
    end
    n_cmp++;
    if (cap[1][6] !== 1'b1 || cap[2][6] !== 1'b0) begin
      n_bad++;
      $display("FAIL single_start got %b%b want 10", cap[1][6], cap[2][6]);
    end
    for (int j = 0; j < FB; j++) begin
      n_cmp++;
      if (cap[2 + j * C + 1][6] !== 1'(seq[j])) begin
        n_bad++;
        $display("FAIL single_bit%0d got %b want %0d", j, cap[2 + j * C + 1][6], seq[j]);
      end
    end
    dn = 0;
    for (int k = 0; k < ncyc; k++) dn += int'(cap[k][4]);
    n_cmp++;
    if (dn !== 1 || cap[FL + 1][4] !== 1'b1) begin
      n_bad++;
      $display("FAIL single_done pulses %0d at_end %b want 1 1", dn, cap[FL + 1][4]);
    end
  endtask

  task automatic test_back_to_back();
    int wr[$];
    int ncyc;
    int run;
    int best;
    int dn;
    apply_reset();
    wr   = '{32'h00, 32'hFF, 32'h3C};
    ncyc = 3 * FL + 12;
    model(wr, ncyc);
    run_frames(wr, ncyc);
    for (int k = 0; k < ncyc; k++) begin
      n_cmp++;
      if (cap[k] !== expv[k]) begin
        n_bad++;
        $display("FAIL b2b cyc %0d got %b want %b", k, cap[k], expv[k]);
      end
    end
    run  = 0;
    best = 0;
    dn   = 0;
    for (int k = 0; k < ncyc; k++) begin
      run = cap[k][5] ? run + 1 : 0;
      if (run > best) best = run;
      dn += int'(cap[k][4]);
    end
    n_cmp++;
    if (best !== 3 * FL || dn !== 3) begin
      n_bad++;
      $display("FAIL b2b_run active %0d done %0d want %0d 3", best, dn, 3 * FL);
    end
  endtask

  task automatic test_overflow();
    int wr[$];
    int ncyc;
    int first;
    logic [7:0] got;
    apply_reset();
    first = int'($urandom_range(0, 255));
    wr    = '{first, -1, 1, 2, 3, 4, 5, 6};
    ncyc  = 5 * FL + 10;
    model(wr, ncyc);
    run_frames(wr, ncyc);
    for (int k = 0; k < ncyc; k++) begin
      n_cmp++;
      if (cap[k] !== expv[k]) begin
        n_bad++;
        $display("FAIL overflow cyc %0d got %b want %b", k, cap[k], expv[k]);
      end
    end
    n_cmp++;
    if (cap[4][3] !== 1'b1 || cap[5][3] !== 1'b0 || cap[7][2:0] !== 3'd4) begin
      n_bad++;
      $display("FAIL overflow_full rdy %b%b cnt %0d want 10 4", cap[4][3], cap[5][3], cap[7][2:0]);
    end
    for (int f = 0; f < 5; f++) begin
      for (int b = 0; b < 8; b++) got[b] = cap[2 + f * FL + (1 + b) * C + 1][6];
      n_cmp++;
      if (got !== ((f == 0) ? first[7:0] : 8'(f))) begin
        n_bad++;
        $display("FAIL overflow_frame%0d got %h want %h", f, got, (f == 0) ? first[7:0] : 8'(f));
      end
    end
  endtask

  task automatic test_random();
    int wr[$];
    int ncyc;
    for (int r = 0; r < 4; r++) begin
      apply_reset();
      wr.delete();
      for (int i = 0; i < 10; i++) begin
        if ($urandom_range(0, 3) == 0) wr.push_back(-1);
        else wr.push_back(int'($urandom_range(0, 255)));
      end
      ncyc = 10 * FL + 20;
      model(wr, ncyc);
      run_frames(wr, ncyc);
      for (int k = 0; k < ncyc; k++) begin
        n_cmp++;
        if (cap[k] !== expv[k]) begin
          n_bad++;
          $display("FAIL random%0d cyc %0d got %b want %b", r, k, cap[k], expv[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int wr[$];
    apply_reset();
    wr = '{32'h81, int'($urandom_range(0, 255)), int'($urandom_range(0, 255))};
    model(wr, 20);
    run_frames(wr, 19);
    n_cmp++;
    if (obs() !== expv[19]) begin
      n_bad++;
      $display("FAIL midrst_before got %b want %b", obs(), expv[19]);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== QUIET) begin
      n_bad++;
      $display("FAIL midrst_async got %b want %b", obs(), QUIET);
    end
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 2 * FL; k++) begin
      tick();
      n_cmp++;
      if (obs() !== QUIET) begin
        n_bad++;
        $display("FAIL midrst_after cyc %0d got %b want %b", k, obs(), QUIET);
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int wr[$];
    int vals[2];
    int ncyc;
    vals = '{32'h07, 32'h03};
    for (int i = 0; i < 2; i++) begin
      apply_reset();
      wr   = '{vals[i]};
      ncyc = FL + 8;
      model(wr, ncyc);
      run_frames(wr, ncyc);
      for (int k = 0; k < ncyc; k++) begin
        n_cmp++;
        if (cap[k] !== expv[k]) begin
          n_bad++;
          $display("FAIL parity%0d cyc %0d got %b want %b", i, k, cap[k], expv[k]);
        end
      end
      n_cmp++;
      if (cap[2 + 9 * C + 1][6] !== ((i == 0) ? 1'b1 : 1'b0) || cap[45][4] !== 1'b1) begin
        n_bad++;
        $display("FAIL parity%0d_bit got %b done %b", i, cap[2 + 9 * C + 1][6], cap[45][4]);
      end
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_random();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Buffered UART transmitter: the sending-side counterpart of the receiver/seven-segment display path. It accepts bytes via a valid/ready handshake into a small FIFO. It serializes each byte as 8N1, LSB first, on one line, at a baud rate set by clock-cycle count. Its serial output drives the receiver's `i_Rx_Serial` directly, so bytes sent here appear on the receive side and its hex displays.

## Interface
- `CLKS_PER_BIT`, 87: clock cycles per serial bit (for example, 10 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH`, 4: byte entries in the transmit FIFO; must be a power of two, ≥ 2.
- `i_Clock`  in  1  single system clock; all logic is on the rising edge.
- `i_Reset_n`  in  1  asynchronous, active-low reset.
- `i_Tx_DV`  in  1  write strobe; accepted when `o_Tx_Ready` is high.
- `i_Tx_Byte`  in  8  byte to send; sampled when a write is accepted.
- `o_Tx_Ready`  out  1  FIFO not full.
- `o_Tx_Serial`  out  1  serial line; idle level is high.
- `o_Tx_Active`  out  1  high while a frame is on the line (START through STOP).
- `o_Tx_Done`  out  1  one-cycle pulse on the last cycle of each stop bit.
- `o_Fifo_Count`  out  $clog2(FIFO_DEPTH+1)  number of bytes currently in the FIFO.

## Operation
- Reset values:
  - `o_Tx_Serial` = 1
  - `o_Tx_Active` = 0
  - `o_Tx_Done` = 0
  - `o_Tx_Ready` = 1
  - `o_Fifo_Count` = 0
  - FIFO pointers = 0
  - FSM = IDLE
  - baud counter and bit index = 0
- Write rule: when `i_Tx_DV` and `o_Tx_Ready` are both high, push `i_Tx_Byte`. When full, `i_Tx_DV` is ignored silently: no overwrite, no error flag.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop into the shift register and go to START.
  - START: drive 0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: drive shift[bit_idx] for `CLKS_PER_BIT` cycles per bit; bit_idx runs 0..7 (LSB first), then go to PARITY if enabled, else STOP.
  - PARITY: drive the parity bit for `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: drive 1 for `CLKS_PER_BIT` cycles.
  - On STOP's final cycle: pulse `o_Tx_Done`. If the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1 and resets to 0 on every state or bit change.
- Simultaneous push and pop: count is unchanged and both operations take effect. A push into a full FIFO is rejected even if a pop occurs in the same cycle, because ready is computed from the registered count.
- Pop from an empty FIFO never happens.
- Pointers wrap modulo `FIFO_DEPTH`.
- Reset asserted mid-frame: the line returns high immediately (asynchronously) and all FIFO contents are discarded.

## Timing
- Write accepted at edge N: `o_Fifo_Count` increments at N+1.
- If IDLE and the FIFO was empty:
  - pop occurs at edge N+1;
  - `o_Tx_Serial` goes low and `o_Tx_Active` goes high after edge N+2.
- First-write-to-start-bit latency is 2 cycles.
- Frame length is 10×`CLKS_PER_BIT` cycles, or 11× with parity.
- Back-to-back frames are contiguous: the stop bit's last cycle is followed immediately by the next start bit.
- `o_Tx_Active` drops on the cycle after the final stop cycle only if the FIFO is empty.
- All outputs are registered except `o_Tx_Ready`, which is decoded from the registered count.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - the PARITY state is compiled in;
  - even parity bit = XOR of the 8 data bits;
  - the frame is 8E1 (11 bits).
- `UART_TX_PARITY_EN` undefined:
  - the PARITY state and its logic are absent;
  - the frame is 8N1 (10 bits);
  - DATA goes straight to STOP.
- The matching receiver must be built with the same setting.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - the default `CLKS_PER_BIT` constant;
  - the line idle level, the start-bit and stop-bit values.
- Sub-module `byte_fifo`: a synchronous FIFO, parameterized by depth, 8-bit wide, with push/pop/full/empty/count outputs. The top level holds only the FSM, baud counter and shift register.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- Reset: hold `i_Reset_n`=0 → `o_Tx_Serial`=1, `o_Tx_Ready`=1, `o_Fifo_Count`=0, `o_Tx_Active`=0.
- Single byte: write 0xA5 at cycle 0.
  - The line goes low at cycle 2.
  - It then emits the sequence 0,1,0,1,0,0,1,0,1,1, with each bit 4 cycles.
  - `o_Tx_Done` pulses once, on cycle 41.
- Back-to-back: write 0x00, 0xFF, 0x3C on consecutive cycles.
  - The three frames are contiguous: 120 cycles of `o_Tx_Active`=1 and no idle gap.
  - `o_Tx_Done` pulses 3 times.
- Overflow: after the first byte pops, write 6 bytes 0x01..0x06 in consecutive cycles.
  - `o_Tx_Ready` drops after 4 are stored and count = 4.
  - 0x05 and 0x06 are dropped.
  - The line carries 0x01..0x04 after the first frame.
- Reset mid-frame: assert reset during the DATA bit 3 of 0x81.
  - The line goes high within the same cycle.
  - After release, with no new writes, no further frame occurs.
- Parity (with `UART_TX_PARITY_EN`): send 0x07 → parity bit = 1; send 0x03 → parity bit = 0; each frame is 44 cycles.
